// File: rtl/tw_rom_seq_ctrl.sv
// Sequencer for the radix-16 twiddle ROM: optional stage-0 reload burst, then gapped stage windows.
// Define TW_ROM_CTRL_RELOAD_EN to build the host COLLECT/BURST reload path.
module tw_rom_seq_ctrl #(
    parameter int unsigned SC_WIDTH  = 3,
    parameter int unsigned S_WIDTH   = 4,
    parameter int unsigned DW        = 64,
    parameter int unsigned ENTRIES   = 4,
    parameter int unsigned STAGE_NUM = 3,
    parameter int unsigned STAGE_LEN = 256,
    parameter int unsigned GAP       = 2
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                tf_valid,
    input  logic [DW-1:0]       tf_data,
    output logic                tf_ready,
    output logic [SC_WIDTH-1:0] stage_counter,
    output logic                CEN,
    output logic [S_WIDTH-1:0]  state,
    output logic [1:0]          ROM4_w,
    output logic [DW-1:0]       horizontal_tf_out,
    output logic                busy,
    output logic                done
);
    // Enumerator values double as the ROM state encoding.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StBurst   = 3'd2,
        StRun     = 3'd4,
        StGap     = 3'd5,
        StDone    = 3'd7
    } st_e;

    localparam int unsigned PW = $clog2(STAGE_LEN + GAP + 1);

    st_e                 st_q, st_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [SC_WIDTH-1:0] sc_q, sc_d;
    logic                cen_q, busy_q, done_q;

`ifdef TW_ROM_CTRL_RELOAD_EN
    localparam int unsigned NW = 2 * ENTRIES;
    localparam int unsigned WW = (NW > 1) ? $clog2(NW) : 1;

    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [DW-1:0] buf_q [NW];
    logic          ready_q;
    logic [1:0]    w_q;
    logic [DW-1:0] hout_q;
    logic          accept;

    assign accept = (st_q == StCollect) && tf_valid;
`endif

    always_comb begin
        st_d   = st_q;
        pcnt_d = pcnt_q;
        sc_d   = sc_q;
`ifdef TW_ROM_CTRL_RELOAD_EN
        wcnt_d = wcnt_q;
`endif
        if (abort && (st_q != StIdle)) begin
            st_d   = StIdle;
            pcnt_d = '0;
            sc_d   = '0;
`ifdef TW_ROM_CTRL_RELOAD_EN
            wcnt_d = '0;
`endif
        end else begin
            unique case (st_q)
                StIdle: begin
                    if (start) begin
`ifdef TW_ROM_CTRL_RELOAD_EN
                        st_d   = StCollect;
                        wcnt_d = '0;
`else
                        st_d   = StRun;
                        pcnt_d = '0;
                        sc_d   = '0;
`endif
                    end
                end
`ifdef TW_ROM_CTRL_RELOAD_EN
                StCollect: begin
                    if (accept) begin
                        if (wcnt_q == WW'(NW - 1)) begin
                            st_d   = StBurst;
                            wcnt_d = '0;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
                StBurst: begin
                    if (wcnt_q == WW'(NW - 1)) begin
                        st_d   = StRun;
                        wcnt_d = '0;
                        pcnt_d = '0;
                        sc_d   = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
`endif
                StRun: begin
                    if (pcnt_q == PW'(STAGE_LEN - 1)) begin
                        pcnt_d = '0;
                        if (sc_q == SC_WIDTH'(STAGE_NUM - 1)) begin
                            st_d = StDone;
                        end else begin
                            st_d = StGap;
                            sc_d = sc_q + 1'b1;
                        end
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (pcnt_q == PW'(GAP - 1)) begin
                        st_d   = StRun;
                        pcnt_d = '0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                StDone: begin
                    st_d = StIdle;
                    sc_d = '0;
                end
                default: st_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with st_q.
    always_ff @(posedge CLK) begin
        if (rst) begin
            st_q   <= StIdle;
            pcnt_q <= '0;
            sc_q   <= '0;
            cen_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            pcnt_q <= pcnt_d;
            sc_q   <= sc_d;
            cen_q  <= (st_d != StRun);
            busy_q <= (st_d != StIdle);
            done_q <= (st_d == StDone);
        end
    end

`ifdef TW_ROM_CTRL_RELOAD_EN
    always_ff @(posedge CLK) begin
        if (rst) begin
            wcnt_q  <= '0;
            ready_q <= 1'b0;
            w_q     <= 2'd0;
            hout_q  <= '0;
            for (int i = 0; i < NW; i++) buf_q[i] <= '0;
        end else begin
            wcnt_q  <= wcnt_d;
            ready_q <= (st_d == StCollect);
            w_q     <= (st_d != StBurst) ? 2'd0 : (wcnt_d < WW'(ENTRIES)) ? 2'd1 : 2'd2;
            hout_q  <= (st_d == StBurst) ? buf_q[wcnt_d] : '0;
            if (accept && !abort) buf_q[wcnt_q] <= tf_data;
        end
    end

    assign tf_ready          = ready_q;
    assign ROM4_w            = w_q;
    assign horizontal_tf_out = hout_q;
`else
    logic unused_host;
    assign unused_host       = ^{tf_valid, tf_data};
    assign tf_ready          = 1'b0;
    assign ROM4_w            = 2'd0;
    assign horizontal_tf_out = '0;
`endif

    assign stage_counter = sc_q;
    assign CEN           = cen_q;
    assign state         = S_WIDTH'(st_q);
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Self-checking bench for tw_rom_seq_ctrl against a timeline model of a run.
// Covers the reload path too when TW_ROM_CTRL_RELOAD_EN is defined.
module tb_tw_rom_seq_ctrl;
    localparam int SCW = 3;
    localparam int SW  = 4;
    localparam int DW  = 64;
    localparam int E   = 4;
    localparam int S   = 3;
    localparam int L   = 256;
    localparam int G   = 2;
    localparam int TOTAL = S * L + (S - 1) * G + 1;

    logic           CLK = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           tf_valid = 1'b0;
    logic [DW-1:0]  tf_data = '0;
    logic           tf_ready;
    logic [SCW-1:0] stage_counter;
    logic           CEN;
    logic [SW-1:0]  state;
    logic [1:0]     ROM4_w;
    logic [DW-1:0]  horizontal_tf_out;
    logic           busy;
    logic           done;

    typedef struct packed {
        logic           cen;
        logic [SCW-1:0] sc;
        logic [SW-1:0]  st;
        logic [1:0]     w;
        logic [DW-1:0]  hd;
        logic           rdy;
        logic           busy;
        logic           done;
    } out_t;

    out_t obs;
    assign obs = {CEN, stage_counter, state, ROM4_w, horizontal_tf_out, tf_ready, busy, done};

    int checks = 0;
    int errors = 0;

    tw_rom_seq_ctrl dut (
        .CLK(CLK), .rst(rst), .start(start), .abort(abort),
        .tf_valid(tf_valid), .tf_data(tf_data), .tf_ready(tf_ready),
        .stage_counter(stage_counter), .CEN(CEN), .state(state), .ROM4_w(ROM4_w),
        .horizontal_tf_out(horizontal_tf_out), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #20_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic out_t idle_out();
        out_t o = '0;
        o.cen = 1'b1;
        return o;
    endfunction

    // Expected outputs r cycles into the stage sequence.
    function automatic out_t run_out(int r);
        out_t o   = idle_out();
        int   per = L + G;
        int   stg = r / per;
        int   pos = r % per;
        o.busy = 1'b1;
        if (r == TOTAL - 1) begin
            o.st = 4'd7; o.done = 1'b1; o.sc = SCW'(S - 1);
        end else if (pos < L) begin
            o.st = 4'd4; o.cen = 1'b0; o.sc = SCW'(stg);
        end else begin
            o.st = 4'd5; o.sc = SCW'(stg + 1);
        end
        return o;
    endfunction

    // Starts a run; with reload enabled, feeds and checks collect and burst first.
    task automatic begin_run(input bit fixed, output bit ok);
        out_t want;
`ifdef TW_ROM_CTRL_RELOAD_EN
        logic [DW-1:0] words [2*E];
        int got = 0;
        int cyc = 0;
        for (int k = 0; k < 2 * E; k++) words[k] = fixed ? DW'(k + 1) : {$urandom, $urandom};
`endif
        ok = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef TW_ROM_CTRL_RELOAD_EN
        while (got < 2 * E && cyc < 200) begin
            want = idle_out(); want.st = 4'd1; want.rdy = 1'b1; want.busy = 1'b1;
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL collect cyc=%0d got=%h exp=%h", cyc, obs, want);
            end
            tf_valid = fixed ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
            tf_data  = tf_valid ? words[got] : {$urandom, $urandom};
            step();
            if (tf_valid) got++;
            cyc++;
        end
        tf_valid = 1'b0;
        checks++;
        if (got != 2 * E) begin
            errors++;
            ok = 1'b0;
            $display("FAIL collect_timeout got=%0d exp=%0d", got, 2 * E);
            return;
        end
        for (int k = 0; k < 2 * E; k++) begin
            want = idle_out(); want.st = 4'd2; want.busy = 1'b1;
            want.w = (k < E) ? 2'd1 : 2'd2;
            want.hd = words[k];
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL burst k=%0d got=%h exp=%h", k, obs, want);
            end
            tf_valid = 1'($urandom_range(0, 1));
            tf_data  = {$urandom, $urandom};
            step();
        end
        tf_valid = 1'b0;
`endif
    endtask

    task automatic test_reset();
        out_t want = idle_out();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", obs, want);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tf_valid = 1'($urandom_range(0, 1));
            tf_data  = {$urandom, $urandom};
            step();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset_idle i=%0d got=%h exp=%h", i, obs, want);
            end
        end
        tf_valid = 1'b0;
    endtask

    task automatic test_full_run(input bit fixed);
        out_t want;
        bit   ok;
        int   done_cnt = 0;
        begin_run(fixed, ok);
        if (!ok) return;
        for (int r = 0; r < TOTAL; r++) begin
            want = run_out(r);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL run r=%0d got=%h exp=%h", r, obs, want);
            end
            if (done) done_cnt++;
            // start while busy (including in DONE) must be ignored
            start    = 1'($urandom_range(0, 1));
            tf_valid = 1'($urandom_range(0, 1));
            tf_data  = {$urandom, $urandom};
            step();
        end
        start = 1'b0;
        tf_valid = 1'b0;
        want = idle_out();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL run_end i=%0d got=%h exp=%h", i, obs, want);
            end
            if (done) done_cnt++;
            step();
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_pulses got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        test_full_run(1'b0);
        test_full_run(1'b0);
    endtask

    task automatic test_abort();
        out_t want;
        bit   ok;
        int   points [4];
        points[0] = 0;
        points[1] = L;
        points[2] = L + G + 7;
        points[3] = $urandom_range(1, TOTAL - 2);
        for (int p = 0; p < 4; p++) begin
            begin_run(1'b0, ok);
            if (!ok) return;
            for (int r = 0; r <= points[p]; r++) begin
                want = run_out(r);
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL abort_pre r=%0d got=%h exp=%h", r, obs, want);
                end
                if (r != points[p]) step();
            end
            abort = 1'b1;
            start = 1'b1;
            step();
            abort = 1'b0;
            start = 1'b0;
            want = idle_out();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL abort_idle p=%0d i=%0d got=%h exp=%h", p, i, obs, want);
                end
                step();
            end
        end
    endtask

`ifdef TW_ROM_CTRL_RELOAD_EN
    task automatic test_abort_burst();
        out_t want;
        bit   ok;
        start = 1'b1;
        step();
        start = 1'b0;
        tf_valid = 1'b1;
        for (int k = 0; k < 2 * E; k++) begin
            tf_data = DW'(100 + k);
            step();
        end
        tf_valid = 1'b0;
        step();
        step();
        want = idle_out(); want.st = 4'd2; want.busy = 1'b1; want.w = 2'd1; want.hd = DW'(102);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL burst_cycle3 got=%h exp=%h", obs, want);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        want = idle_out();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL burst_abort i=%0d got=%h exp=%h", i, obs, want);
            end
            step();
        end
        begin_run(1'b0, ok);
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask
`endif

    task automatic test_rst_mid_run();
        out_t want;
        bit   ok;
        begin_run(1'b0, ok);
        if (!ok) return;
        for (int r = 0; r < L + G + 10; r++) begin
            want = run_out(r);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL rst_pre r=%0d got=%h exp=%h", r, obs, want);
            end
            step();
        end
        rst = 1'b1;
        step();
        want = idle_out();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL rst_mid got=%h exp=%h", obs, want);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL rst_after got=%h exp=%h", obs, want);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_full_run(1'b1);
        test_back_to_back();
        test_abort();
`ifdef TW_ROM_CTRL_RELOAD_EN
        test_abort_burst();
`endif
        test_rst_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
